// File: rtl/cic_cfg_master.sv
// cic_cfg_master: one-shot host-side sequencer that configures a CIC controller.
// A request pulse on isConfig is followed by three signed words (numsecs, dcef,
// scale) on Data_Config, then the master waits for the controller's level done.
// Build option: define CIC_CFG_TIMEOUT_EN to bound the wait for done with a
// TIMEOUT_CYCLES-cycle counter; without it the wait is unbounded and
// cfg_timeout is tied low.
module cic_cfg_master #(
  parameter int CIC_CONFIG_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES        = 1024
) (
  input  logic                                    CLK,
  input  logic                                    nRST,
  input  logic                                    cfg_start,
  input  logic signed [CIC_CONFIG_DATA_WIDTH-1:0] cfg_numsecs,
  input  logic signed [CIC_CONFIG_DATA_WIDTH-1:0] cfg_dcef,
  input  logic signed [CIC_CONFIG_DATA_WIDTH-1:0] cfg_scale,
  output logic                                    isConfig,
  output logic signed [CIC_CONFIG_DATA_WIDTH-1:0] Data_Config,
  input  logic                                    isConfigACK,
  input  logic                                    isConfigDone,
  output logic                                    cfg_busy,
  output logic                                    cfg_done,
  output logic                                    cfg_timeout,
  output logic                                    cfg_ack_seen
);

  localparam int W = CIC_CONFIG_DATA_WIDTH;

  // Catch an out-of-range limit at elaboration rather than silently wrapping
  // the 16-bit counter.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("cic_cfg_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE, REQ, W0, W1, W2, GUARD, WAIT_DONE, FIN
  } state_t;

  state_t              state_q;
  logic signed [W-1:0] numsecs_q, dcef_q, scale_q;
  logic signed [W-1:0] data_q;
  logic                is_config_q;
  logic                busy_q;
  logic                done_q;
  logic                ack_seen_q;

`ifdef CIC_CFG_TIMEOUT_EN
  // The counter holds the number of WAIT_DONE cycles already completed, so the
  // limit is reached on the edge where it would step from TIMEOUT_CYCLES-1.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
  logic        timeout_q;
`endif

  // Sequencer: state, shadow words and all registered outputs in one process.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      numsecs_q   <= '0;
      dcef_q      <= '0;
      scale_q     <= '0;
      data_q      <= '0;
      is_config_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_seen_q  <= 1'b0;
`ifdef CIC_CFG_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      // Pulses and the word bus default low; each state re-drives its own.
      is_config_q <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            numsecs_q   <= cfg_numsecs;
            dcef_q      <= cfg_dcef;
            scale_q     <= cfg_scale;
            ack_seen_q  <= 1'b0;
`ifdef CIC_CFG_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
            busy_q      <= 1'b1;
            is_config_q <= 1'b1;
            // Shadow is not loaded yet on this edge, so drive the host word.
            data_q      <= cfg_numsecs;
            state_q     <= REQ;
          end
        end
        REQ: begin
          data_q  <= numsecs_q;
          state_q <= W0;
        end
        W0: begin
          // ACK is informational only; word timing never waits on it.
          if (isConfigACK) ack_seen_q <= 1'b1;
          data_q  <= dcef_q;
          state_q <= W1;
        end
        W1: begin
          data_q  <= scale_q;
          state_q <= W2;
        end
        W2: begin
          state_q <= GUARD;
        end
        GUARD: begin
          // One dead cycle so a done left over from a previous run is ignored.
`ifdef CIC_CFG_TIMEOUT_EN
          cnt_q   <= '0;
`endif
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Done is checked first so it wins a tie with the timeout limit.
          if (isConfigDone) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end
`ifdef CIC_CFG_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign isConfig     = is_config_q;
  assign Data_Config  = data_q;
  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign cfg_ack_seen = ack_seen_q;
`ifdef CIC_CFG_TIMEOUT_EN
  assign cfg_timeout  = timeout_q;
`else
  assign cfg_timeout  = 1'b0;
`endif

endmodule

// File: doc/cic_cfg_master.md
CIC_CFG_MASTER -- requirements
Module: cic_cfg_master

Interface
REQ-001 Parameter CIC_CONFIG_DATA_WIDTH, default 16, is the width of each configuration word.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, is the WAIT_DONE cycle limit; legal range 1..65535.
REQ-003 CLK  in  1  single clock; all logic on rising edge.
REQ-004 nRST  in  1  reset, synchronous, active-low.
REQ-005 cfg_start  in  1  one-cycle host request to run a configuration.
REQ-006 cfg_numsecs, cfg_dcef, cfg_scale  in  CIC_CONFIG_DATA_WIDTH each  host words, signed.
REQ-007 isConfig  out  1  configuration request to the CIC controller.
REQ-008 Data_Config  out  CIC_CONFIG_DATA_WIDTH  serial word bus to the controller's data input, signed.
REQ-009 isConfigACK  in  1  controller acknowledge, status only.
REQ-010 isConfigDone  in  1  controller level done, the AND of its sub-block dones.
REQ-011 cfg_busy  out  1  high from leaving IDLE until returning to IDLE.
REQ-012 cfg_done  out  1  one-cycle pulse on successful completion.
REQ-013 cfg_timeout  out  1  sticky error flag; cleared by an accepted cfg_start.
REQ-014 cfg_ack_seen  out  1  sticky; set when isConfigACK is sampled 1 in W0; cleared by an accepted cfg_start.

Function
REQ-015 The FSM SHALL use these states: IDLE, REQ, W0, W1, W2, GUARD, WAIT_DONE, FIN.
REQ-016 In IDLE, cfg_start=1 SHALL latch all three host words into shadow registers, clear both sticky flags and enter REQ.
REQ-017 cfg_start SHALL be ignored in every state other than IDLE.
REQ-018 In REQ, outputs SHALL be isConfig=1 and Data_Config=numsecs for exactly 1 cycle, then the FSM enters W0.
REQ-019 In W0, outputs SHALL be isConfig=0 and Data_Config=numsecs.
- Controller captures word index 0 at the end of W0.
- isConfigACK is sampled here to set cfg_ack_seen.
REQ-020 W1 SHALL drive Data_Config=dcef, and W2 SHALL drive Data_Config=scale, 1 cycle each.
REQ-021 The word order SHALL be fixed: numsecs, dcef, scale.
REQ-022 The word timing SHALL be independent of isConfigACK, since ACK is not re-asserted on controller reconfiguration.
REQ-023 Outside REQ through W2, Data_Config SHALL hold 0.
REQ-024 GUARD SHALL last 1 cycle so that stale isConfigDone is ignored, then the FSM enters WAIT_DONE.
REQ-025 In WAIT_DONE, isConfigDone sampled 1 SHALL move the FSM to FIN.
REQ-026 FIN SHALL assert cfg_done for 1 cycle and return to IDLE.
REQ-027 cfg_busy SHALL drop in the cycle after FIN.
REQ-028 Latency from cfg_start sampled to cfg_done high SHALL be 7 cycles when isConfigDone is already 1 on the first WAIT_DONE cycle.
REQ-029 If isConfigDone rises in the same cycle as the timeout limit is reached, done SHALL win: FIN is entered and cfg_timeout stays 0.
REQ-030 Shadow words SHALL NOT change while busy, even if the host inputs change.
REQ-031 isConfig SHALL be high only in REQ, for exactly one cycle per accepted start.

Reset
REQ-032 When nRST=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-033 On reset, all outputs SHALL be 0: isConfig, Data_Config, cfg_busy, cfg_done, cfg_timeout and cfg_ack_seen.
REQ-034 On reset, the shadow registers and the timeout counter SHALL be 0.
REQ-035 Reset asserted mid-sequence (REQ..FIN) SHALL abort at that edge with no cfg_done pulse.
REQ-036 A cfg_start present in the first cycle after nRST returns to 1 SHALL be accepted.

Configuration
REQ-037 Macro CIC_CFG_TIMEOUT_EN SHALL compile the WAIT_DONE timeout in or out.
REQ-038 With CIC_CFG_TIMEOUT_EN defined:
- A 16-bit counter SHALL clear on entering WAIT_DONE and increment each WAIT_DONE cycle.
- When the counter reaches TIMEOUT_CYCLES with isConfigDone=0, the FSM SHALL set cfg_timeout=1 and return to IDLE without a cfg_done pulse.
REQ-039 With CIC_CFG_TIMEOUT_EN undefined:
- WAIT_DONE SHALL wait indefinitely.
- cfg_timeout SHALL be constant 0.
- No counter logic SHALL exist.

Verification
REQ-040 Basic sequence: start with numsecs=5, dcef=16, scale=-3, and isConfigDone=1 from GUARD onward. Required: isConfig high 1 cycle; Data_Config = 5, 5, 16, -3 on consecutive cycles; cfg_done 7 cycles after start; Data_Config = 0 afterwards.
REQ-041 ACK status: model the controller with ACK set one cycle after isConfig. Required: cfg_ack_seen=1. Run a second start with ACK held 0 (reconfig path). Required: identical word timing and cfg_ack_seen=0.
REQ-042 Busy rejection: second cfg_start during W1 with numsecs=9. Required: ignored; the running words stay 5, 16, -3; exactly one isConfig pulse and one cfg_done.
REQ-043 Timeout: macro on, TIMEOUT_CYCLES=8, isConfigDone=0. Required: cfg_timeout=1 after 8 WAIT_DONE cycles; no cfg_done; the next start clears cfg_timeout. Macro off: still busy after 1000 cycles.
REQ-044 Reset mid-sequence: nRST=0 in W1. Required: next-edge isConfig=0, Data_Config=0, cfg_busy=0, no cfg_done. A start issued right after reset release completes normally.
REQ-045 Done/timeout tie: isConfigDone rises on the 8th WAIT_DONE cycle with TIMEOUT_CYCLES=8. Required: cfg_done=1 and cfg_timeout=0.
